// File: rtl/simmem_pkg.sv
// Shared types for the simulated-memory response path: slot layout and default widths.
package simmem_pkg;

  localparam int unsigned SimmemIdWidth    = 8;
  localparam int unsigned SimmemDelayWidth = 8;
  localparam int unsigned SimmemNumSlots   = 16;

  typedef struct packed {
    logic                        valid;
    logic [SimmemIdWidth-1:0]    id;
    logic [SimmemDelayWidth-1:0] counter;
  } slot_t;

endpackage

// File: rtl/simmem_age_matrix.sv
// NumSlots x NumSlots insertion-order tracker; grants the oldest requesting slot.
module simmem_age_matrix #(
  parameter int unsigned NumSlots = 16
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NumSlots-1:0]                valid_i,
  input  logic [NumSlots-1:0]                insert_i,
  input  logic [NumSlots-1:0]                free_i,
  input  logic [NumSlots-1:0]                req_i,
  output logic [NumSlots-1:0]                grant_o,
  output logic [NumSlots-1:0][NumSlots-1:0]  older_o
);

  logic [NumSlots-1:0][NumSlots-1:0] older_q, older_d;

  // older_q[i][j]: slot i was inserted before slot j
  always_comb begin
    older_d = '0;
    for (int unsigned i = 0; i < NumSlots; i++) begin
      for (int unsigned j = 0; j < NumSlots; j++) begin
        if (free_i[i] || free_i[j] || i == j) begin
          older_d[i][j] = 1'b0;
        end else if (insert_i[j]) begin
          older_d[i][j] = valid_i[i];
        end else if (insert_i[i]) begin
          older_d[i][j] = 1'b0;
        end else begin
          older_d[i][j] = older_q[i][j];
        end
      end
    end
  end

  always_comb begin
    grant_o = '0;
    for (int unsigned i = 0; i < NumSlots; i++) begin
      grant_o[i] = req_i[i];
      for (int unsigned j = 0; j < NumSlots; j++) begin
        if (req_i[j] && older_q[j][i]) grant_o[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      older_q <= '0;
    end else begin
      older_q <= older_d;
    end
  end

  assign older_o = older_q;

endmodule

// File: rtl/simmem_delay_releaser.sv
// Per-request delay tracker driving the response bank's per-ID release enables.
// Optional SIMMEM_RELEASER_STATS_EN adds max_occupancy_o (peak valid slots since reset).
module simmem_delay_releaser
  import simmem_pkg::*;
#(
  parameter int unsigned IDWidth    = SimmemIdWidth,
  parameter int unsigned NumSlots   = SimmemNumSlots,
  parameter int unsigned DelayWidth = SimmemDelayWidth
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [IDWidth-1:0]         in_id_i,
  input  logic [DelayWidth-1:0]      in_delay_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic                       released_valid_i,
  input  logic [IDWidth-1:0]         released_id_i,
`ifdef SIMMEM_RELEASER_STATS_EN
  output logic [$clog2(NumSlots):0]  max_occupancy_o,
`endif
  output logic [2**IDWidth-1:0]      release_en_o
);

  slot_t slot_q [NumSlots];
  slot_t slot_d [NumSlots];

  logic [NumSlots-1:0]               valid, expired, rel_req, head;
  logic [NumSlots-1:0]               ins_oh, free_oh, grant;
  logic [NumSlots-1:0][NumSlots-1:0] older;
  logic                              found, rel_fire;

  always_comb begin
    for (int unsigned i = 0; i < NumSlots; i++) begin
      valid[i]   = slot_q[i].valid;
      expired[i] = slot_q[i].valid && (slot_q[i].counter == '0);
      rel_req[i] = slot_q[i].valid && (slot_q[i].id == released_id_i);
    end
  end

  assign in_ready_o = ~&valid;

  always_comb begin
    ins_oh = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < NumSlots; i++) begin
      if (!valid[i] && !found) begin
        ins_oh[i] = in_valid_i && in_ready_o;
        found     = 1'b1;
      end
    end
  end

  // A release whose ID is not enabled is a protocol error and is dropped.
  assign rel_fire = released_valid_i && release_en_o[released_id_i];
  assign free_oh  = grant & {NumSlots{rel_fire}};

  simmem_age_matrix #(
    .NumSlots (NumSlots)
  ) u_age_matrix (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .valid_i  (valid),
    .insert_i (ins_oh),
    .free_i   (free_oh),
    .req_i    (rel_req),
    .grant_o  (grant),
    .older_o  (older)
  );

  always_comb begin
    for (int unsigned i = 0; i < NumSlots; i++) begin
      slot_d[i] = slot_q[i];
      if (slot_q[i].valid && slot_q[i].counter != '0) begin
        slot_d[i].counter = slot_q[i].counter - 1'b1;
      end
      if (free_oh[i]) slot_d[i].valid = 1'b0;
      if (ins_oh[i]) begin
        slot_d[i].valid   = 1'b1;
        slot_d[i].id      = in_id_i;
        slot_d[i].counter = in_delay_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NumSlots; i++) slot_q[i] <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  // Only the oldest valid entry of each ID may raise that ID's enable.
  always_comb begin
    head         = '0;
    release_en_o = '0;
    for (int unsigned i = 0; i < NumSlots; i++) begin
      head[i] = valid[i];
      for (int unsigned j = 0; j < NumSlots; j++) begin
        if (valid[j] && slot_q[j].id == slot_q[i].id && older[j][i]) head[i] = 1'b0;
      end
      if (head[i] && expired[i]) release_en_o[slot_q[i].id] = 1'b1;
    end
  end

`ifdef SIMMEM_RELEASER_STATS_EN
  localparam int unsigned OccW = $clog2(NumSlots) + 1;
  logic [OccW-1:0] occ, max_occ_q;

  always_comb begin
    occ = '0;
    for (int unsigned i = 0; i < NumSlots; i++) occ = occ + OccW'(valid[i]);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      max_occ_q <= '0;
    end else if (occ > max_occ_q) begin
      max_occ_q <= occ;
    end
  end

  assign max_occupancy_o = max_occ_q;
`endif

  ReleaseOnlyWhenEnabled: assert property (@(posedge clk_i) disable iff (!rst_ni)
    released_valid_i |-> release_en_o[released_id_i]);

endmodule
